// File: rtl/spi_dac_rx_pkg.sv
// Shared types and defaults for the SPI DAC receiver slice.
package spi_dac_rx_pkg;

  localparam int unsigned DATA_W_DEF = 12;

  typedef enum logic [1:0] {IDLE, LEAD, SHIFT, OVER} rx_state_t;

endpackage

// File: rtl/spi_dac_rx_if.sv
// Serial input lines and parallel result of the SPI DAC receiver.
interface spi_dac_rx_if
  import spi_dac_rx_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
);

  logic              SCLK;
  logic              CS;
  logic              MOSI;
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic              frame_err;
  logic              busy;

  modport master (output SCLK, CS, MOSI, input dout, dout_valid, frame_err, busy);
  modport slave  (input SCLK, CS, MOSI, output dout, dout_valid, frame_err, busy);

endinterface

// File: rtl/spi_dac_rx_sync_edge.sv
// Multi-flop synchronizer for one asynchronous line, plus edge detection
// against a one-cycle-delayed copy of the synchronized level.
module spi_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= {SYNC_STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level_o = sync_q[SYNC_STAGES-1];
  assign rise_o  = level_o & ~prev_q;
  assign fall_o  = ~level_o & prev_q;

endmodule

// File: rtl/spi_dac_rx.sv
// Oversampling SPI receiver: rebuilds one LSB-first word per CS frame,
// flagging frames whose SCLK falling-edge count is wrong.
module spi_dac_rx
  import spi_dac_rx_pkg::*;
#(
  parameter int unsigned DATA_W      = DATA_W_DEF,
  parameter int unsigned LEAD_EDGES  = 1,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  spi_dac_rx_if.slave bus
);

  localparam int unsigned    CW      = $clog2(DATA_W + 1);
  localparam logic [CW-1:0]  DW_C    = CW'(DATA_W);
  localparam logic [CW-1:0]  LEAD_C  = CW'(LEAD_EDGES);
  localparam int unsigned    FW      = $clog2(SYNC_STAGES + 2);
  localparam logic [FW-1:0]  FLUSH_C = FW'(SYNC_STAGES + 1);

  logic sclk_lvl, sclk_rise, sclk_fall;
  logic cs_lvl, cs_rise, cs_fall;
  logic mosi_lvl, mosi_rise, mosi_fall;
  logic unused_edges;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
    .clk(clk), .reset(reset), .d_i(bus.SCLK),
    .level_o(sclk_lvl), .rise_o(sclk_rise), .fall_o(sclk_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs (
    .clk(clk), .reset(reset), .d_i(bus.CS),
    .level_o(cs_lvl), .rise_o(cs_rise), .fall_o(cs_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi (
    .clk(clk), .reset(reset), .d_i(bus.MOSI),
    .level_o(mosi_lvl), .rise_o(mosi_rise), .fall_o(mosi_fall)
  );

  assign unused_edges = ^{sclk_lvl, sclk_rise, mosi_rise, mosi_fall};

  rx_state_t         state_q, state_d;
  logic [CW-1:0]     edge_q, edge_d, edge_inc;
  logic [CW-1:0]     bit_q, bit_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;
  logic [FW-1:0]     flush_q, flush_d;
  logic              armed_q, armed_d;
  logic              overflow;

  // The CS synchronizer resets high, so a CS line held low across reset
  // release looks like a fall; frames are only accepted once CS has been
  // seen high after the chain has flushed.
  always_comb begin
    flush_d = (flush_q == FLUSH_C) ? flush_q : flush_q + 1'b1;
    armed_d = armed_q | ((flush_q == FLUSH_C) & cs_lvl);
  end

  always_comb begin
    state_d  = state_q;
    edge_d   = edge_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    dout_d   = dout_q;
    valid_d  = 1'b0;
    err_d    = 1'b0;
    edge_inc = (edge_q == '1) ? edge_q : edge_q + 1'b1;
    overflow = sclk_fall & (bit_q == DW_C);

    unique case (state_q)
      IDLE: begin
        if (cs_fall && armed_q) begin
          edge_d  = '0;
          bit_d   = '0;
          shift_d = '0;
          state_d = (LEAD_EDGES == 0) ? SHIFT : LEAD;
        end
      end
      LEAD: begin
        if (sclk_fall) begin
          edge_d = edge_inc;
          if (edge_inc >= LEAD_C) begin
            state_d = SHIFT;
            bit_d   = '0;
          end
        end
        if (cs_rise) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end
      end
      SHIFT: begin
        // A fall coinciding with the CS rise is counted before judging the frame.
        if (sclk_fall) begin
          if (bit_q < DW_C) begin
            for (int unsigned i = 0; i < DATA_W; i++) begin
              if (CW'(i) == bit_q) shift_d[i] = mosi_lvl;
            end
            bit_d = bit_q + 1'b1;
          end else begin
            state_d = OVER;
          end
        end
        if (cs_rise) begin
          state_d = IDLE;
          if (bit_d == DW_C && !overflow) begin
            dout_d  = shift_d;
            valid_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      OVER: begin
        if (cs_rise) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      edge_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      flush_q <= '0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      edge_q  <= edge_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      flush_q <= flush_d;
      armed_q <= armed_d;
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = valid_q;
  assign bus.frame_err  = err_q;
  assign bus.busy       = busy_q;

endmodule
